// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the MIPS HI/LO register pair.
// One radix-2 step per cycle; sign correction and HI/LO write in a final FIX cycle.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO write HI/LO directly here
// CALC  | 32 shift-add (multiply) or restoring shift-subtract (divide) steps
// FIX   | apply result signs, write HI/LO, pulse Done
module mul_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t state, state_nxt;

  logic [31:0] hi_q, lo_q;
  logic [31:0] acc_hi, acc_lo;
  logic [31:0] opnd;
  logic [31:0] a_raw;
  logic [4:0]  cnt;
  logic        is_div, is_sgn, sgn_a, sgn_b, div_zero;
  logic        done_q;

  logic        md_req;
  logic        req_sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        neg_res;

  assign md_req  = Start && (state == S_IDLE) && !Op[2];
  assign req_sgn = !Op[0];

  // signed ops iterate on magnitudes; 0x80000000 maps to itself as an unsigned magnitude
  assign a_mag = (req_sgn && A[31]) ? (~A + 32'd1) : A;
  assign b_mag = (req_sgn && B[31]) ? (~B + 32'd1) : B;

  // multiply: acc_lo holds the multiplier and shifts right as the product fills in
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);

  // divide: acc_lo holds the dividend, shifting out into the partial remainder
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[31:0] - opnd;

  assign neg_res  = is_sgn && (sgn_a ^ sgn_b);
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? (~prod + 64'd1) : prod;
  assign quo_fix  = neg_res ? (~acc_lo + 32'd1) : acc_lo;
  assign rem_fix  = (is_sgn && sgn_a) ? (~acc_hi + 32'd1) : acc_hi;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (md_req) state_nxt = S_CALC;
      S_CALC: if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd     <= 32'd0;
      a_raw    <= 32'd0;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      is_sgn   <= 1'b0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_hi   <= 32'd0;
                acc_lo   <= Op[1] ? a_mag : b_mag;
                opnd     <= Op[1] ? b_mag : a_mag;
                a_raw    <= A;
                cnt      <= 5'd0;
                is_div   <= Op[1];
                is_sgn   <= req_sgn;
                sgn_a    <= req_sgn && A[31];
                sgn_b    <= req_sgn && B[31];
                div_zero <= (B == 32'd0);
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc_hi <= div_ge ? div_diff : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
        end
        S_FIX: begin
          if (is_div) begin
            // divide by zero reports the raw dividend, not the sign-corrected remainder
            if (div_zero) begin
              hi_q <= a_raw;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign Busy  = (state != S_IDLE);
  assign Done  = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] HiOut, LoOut;
  logic        Busy, Done;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiOut(HiOut), .LoOut(LoOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // {HI, LO} as the architecture defines them, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // poke_at>0 drives an MTHI request into the sample after edge E<poke_at>
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input string tag);
    int lat, busy_cyc;
    logic [63:0] r;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom;
    busy_cyc = Busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Done) begin
        lat = k;
        break;
      end
      if (Busy) busy_cyc++;
      if (k == poke_at) begin
        Start = 1'b1; Op = 3'b100; A = 32'h0BAD_F00D;
      end
    end
    Start = 1'b0;
    r = ref_md(op, a, b);
    m_hi = r[63:32];
    m_lo = r[31:0];
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cyc), 64'd33);
    check({tag, " hi"}, 64'(HiOut), 64'(m_hi));
    check({tag, " lo"}, 64'(LoOut), 64'(m_lo));
    check({tag, " busy_after"}, 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check({tag, " done_pulse"}, 64'(Done), 64'd0);
    check({tag, " hi_hold"}, 64'(HiOut), 64'(m_hi));
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string tag);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = $urandom;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (op == 3'b100) m_hi = a;
    if (op == 3'b101) m_lo = a;
    check({tag, " hi"}, 64'(HiOut), 64'(m_hi));
    check({tag, " lo"}, 64'(LoOut), 64'(m_lo));
    check({tag, " busy"}, 64'(Busy), 64'd0);
    check({tag, " done"}, 64'(Done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    #2;
    check("reset hi", 64'(HiOut), 64'd0);
    check("reset lo", 64'(LoOut), 64'd0);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    run_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, "mult_m1x2");
    check("mult_m1x2 hi_const", 64'(HiOut), 64'hFFFF_FFFF);
    check("mult_m1x2 lo_const", 64'(LoOut), 64'hFFFF_FFFE);
    run_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, "multu_x2");
    check("multu_x2 hi_const", 64'(HiOut), 64'h1);
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    check("multu_max hi_const", 64'(HiOut), 64'hFFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    check("div_m7_2 lo_const", 64'(LoOut), 64'hFFFF_FFFD);
    run_md(3'd3, 32'd100, 32'd7, 0, "divu_100_7");
    check("divu_100_7 lo_const", 64'(LoOut), 64'd14);
    run_md(3'd3, 32'd7, 32'd0, 0, "divu_by0");
    check("divu_by0 lo_const", 64'(LoOut), 64'hFFFF_FFFF);
    run_md(3'd2, 32'hFFFF_FFF9, 32'd0, 0, "div_by0_neg");
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    check("div_ovf lo_const", 64'(LoOut), 64'h8000_0000);

    run_mt(3'b100, 32'h1234_5678, "mthi");
    run_mt(3'b101, 32'h9ABC_DEF0, "mtlo");
    run_mt(3'b110, 32'h5555_AAAA, "reserved");

    run_md(3'd0, 32'd1234, 32'hFFFF_FF00, 5, "mthi_while_busy");
    run_md(3'd3, 32'hDEAD_0000, 32'd3, 32, "start_at_e33");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        run_mt(3'(3'b100 + $urandom_range(0, 3)), $urandom, "rand_mt");
      run_md(3'($urandom_range(0, 3)), pick(), pick(), 0, "rand_md");
    end

    run_mt(3'b100, 32'hCAFE_0001, "pre_reset_mthi");
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'h0001_0003; B = 32'h0007_0005;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("async_reset hi", 64'(HiOut), 64'd0);
    check("async_reset lo", 64'(LoOut), 64'd0);
    check("async_reset busy", 64'(Busy), 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (Done) done_seen++;
    end
    check("post_reset no_done", 64'(done_seen), 64'd0);
    check("post_reset lo", 64'(LoOut), 64'd0);
    run_md(3'd0, 32'd3, 32'd5, 0, "mult_3x5");
    check("mult_3x5 lo_const", 64'(LoOut), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit owning the HI/LO register pair of the MIPS datapath. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO requests from the EX stage and produces a 64-bit product or a quotient/remainder over 33 cycles. Its HiOut/LoOut outputs feed the downstream 32-bit 2:1 writeback-select mux that picks MFHI/MFLO data versus the ALU result. Busy drives the hazard unit's stall on any MFHI/MFLO or new HI/LO request.

## Interface
- No parameters; datapath width fixed at 32 bits.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe, sampled on rising Clk.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- A  in  32  multiplicand / dividend / MTHI-MTLO data.
- B  in  32  multiplier / divisor.
- HiOut  out  32  HI register.
- LoOut  out  32  LO register.
- Busy  out  1  high while a mul/div is in flight.
- Done  out  1  one-cycle pulse when HI/LO receive a mul/div result.

## Operation
- Reset low, at any time including mid-operation: state→IDLE; HiOut=0, LoOut=0, Busy=0, Done=0; iteration counter and working registers cleared; the in-flight result is discarded.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Busy=0:
  - Op MULT/MULTU/DIV/DIVU: latch operands, converting to magnitudes for signed ops and recording result signs; counter=0; →CALC; Busy←1.
  - Op MTHI: HI←A. Op MTLO: LO←A. Stay IDLE; Busy and Done stay 0.
  - Reserved Op: no effect.
- Start while Busy=1 is ignored entirely, including MTHI/MTLO. No queueing.
- CALC: one radix-2 step per cycle for 32 cycles, counter 0..31; →FIX when counter=31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
- FIX, one cycle: apply signs, write HI/LO, Busy←0, Done←1, →IDLE.
  - Signed product: negate the 64-bit magnitude if operand signs differ.
  - Signed quotient: negate if signs differ. Signed remainder takes the dividend's sign.
  - MULT/MULTU: HI=product[63:32], LO=product[31:0]. DIV/DIVU: LO=quotient, HI=remainder.
- Divide by zero (B=0), signed or unsigned: LO=0xFFFFFFFF, HI=A. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- HI/LO hold their values at all other times. HiOut/LoOut are driven directly from the registers.

## Timing
- E0 = the edge sampling Start with a mul/div Op.
- Busy=1 after E0. CALC iterations occur at E1..E32. At E33, HI/LO are written, Busy←0 and Done←1. Done←0 at E34.
- Latency is 33 cycles from Start to valid HiOut/LoOut, with the result stable after E33.
- A new Start sampled at E33 is rejected because Busy is still 1. Start at E34 or later is accepted.
- MTHI/MTLO: register is updated at E0; visible the cycle after.
- A and B need only be valid at E0.

## Test plan
- Reset, then MULT A=0xFFFFFFFF, B=0x00000002 -> Done 33 cycles later; HI=0xFFFFFFFF, LO=0xFFFFFFFE; Busy high for exactly 33 cycles.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. Then MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> HiOut/LoOut update one cycle each, Done stays 0. MTHI issued while Busy -> HI unchanged.
- Start MULT; drive Reset low at E10 -> HiOut=LoOut=0, Busy=0 immediately without waiting for a clock edge; no Done pulse. After release, a new MULT 3×5 -> LO=15, HI=0.
